// File: rtl/panda_risc_v_mul_pkg.sv
// Shared encodings for the PANDA RISC-V multiply unit: operation modes, FSM states
// and the digit-step count helper.
package panda_risc_v_mul_pkg;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,
    MODE_MULH   = 2'b01,
    MODE_MULHSU = 2'b10,
    MODE_MULHU  = 2'b11
  } mul_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  // ceil((dw+1)/kw): digit steps covering the (dw+1)-bit extended multiplier.
  function automatic int mul_steps(input int dw, input int kw);
    return (dw + kw) / kw;
  endfunction

  function automatic logic mode_a_signed(input mul_mode_e m);
    return (m == MODE_MULH) || (m == MODE_MULHSU);
  endfunction

  function automatic logic mode_b_signed(input mul_mode_e m);
    return m == MODE_MULH;
  endfunction

endpackage

// File: rtl/panda_risc_v_mul_unit_fifo.sv
// Register-based first-word-fall-through FIFO; the head entry is visible on rdata_o
// whenever empty_o is low. flush_i empties it on the next edge.
module panda_risc_v_mul_unit_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/panda_risc_v_mul_unit.sv
// RISC-V M-extension multiplier: buffered requests, digit-serial signed/unsigned
// multiply with zero-operand and last-product shortcuts, in-order results.
module panda_risc_v_mul_unit
  import panda_risc_v_mul_pkg::*;
#(
  parameter int inst_id_width    = 4,
  parameter int data_width       = 32,
  parameter int digit_width      = 8,
  parameter int in_buf_depth     = 2,
  parameter int simulation_delay = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [data_width-1:0]    s_mul_req_op_a,
  input  logic [data_width-1:0]    s_mul_req_op_b,
  input  logic [1:0]               s_mul_req_mode,
  input  logic [4:0]               s_mul_req_rd_id,
  input  logic [inst_id_width-1:0] s_mul_req_inst_id,
  input  logic                     s_mul_req_valid,
  output logic                     s_mul_req_ready,
  output logic [data_width-1:0]    m_mul_res_data,
  output logic [4:0]               m_mul_res_rd_id,
  output logic [inst_id_width-1:0] m_mul_res_inst_id,
  output logic                     m_mul_res_valid,
  input  logic                     m_mul_res_ready,
  input  logic                     flush
);
  localparam int W      = data_width;
  localparam int K      = digit_width;
  localparam int PW     = 2 * W;
  localparam int STEPS  = mul_steps(W, K);
  localparam int BW     = STEPS * K;
  localparam int CNT_W  = $clog2(STEPS);
  localparam int FIFO_W = 2 * W + 2 + 5 + inst_id_width;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  if (data_width < 8 || data_width > 64 || digit_width < 1 || digit_width > data_width ||
      in_buf_depth < 1 || in_buf_depth > 8 || simulation_delay < 0) begin : g_param_check
    $error("panda_risc_v_mul_unit: illegal parameter value");
  end

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [FIFO_W-1:0]        fifo_rdata;

  logic [W-1:0]             hd_a;
  logic [W-1:0]             hd_b;
  logic [1:0]               hd_mode_raw;
  logic [4:0]               hd_rd;
  logic [inst_id_width-1:0] hd_inst;
  mul_mode_e                hd_mode;
  logic                     hd_sa;
  logic                     hd_sb;
  logic                     hd_zero;
  logic                     cache_hit;

  mul_state_e               state_q;
  mul_state_e               state_d;
  logic                     start_calc;
  logic                     start_fast;
  logic                     calc_step;
  logic                     calc_last;

  logic signed [PW-1:0]     a_sh_q;
  logic [BW-1:0]            b_sh_q;
  logic signed [PW-1:0]     acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [K-1:0]             dig;
  logic                     dig_sign;
  logic signed [PW-1:0]     dig_ext;
  logic signed [PW-1:0]     pp;
  logic signed [PW-1:0]     acc_nxt;

  logic [W-1:0]             res_data_q;
  logic [4:0]               res_rd_q;
  logic [inst_id_width-1:0] res_inst_q;

  logic                     cache_vld_q;
  logic [PW-1:0]            cache_prod_q;
  logic [W-1:0]             cache_a_q;
  logic [W-1:0]             cache_b_q;
  logic                     cache_sa_q;
  logic                     cache_sb_q;

  function automatic logic [W-1:0] sel_half(input logic [PW-1:0] prod, input mul_mode_e m);
    return (m == MODE_MUL) ? prod[W-1:0] : prod[PW-1:W];
  endfunction

  assign fifo_push = s_mul_req_valid && s_mul_req_ready && !flush;

  panda_risc_v_mul_unit_fifo #(
    .DEPTH (in_buf_depth),
    .WIDTH (FIFO_W)
  ) u_in_buf (
    .clk     (clk),
    .resetn  (resetn),
    .flush_i (flush),
    .push_i  (fifo_push),
    .wdata_i ({s_mul_req_op_a, s_mul_req_op_b, s_mul_req_mode, s_mul_req_rd_id, s_mul_req_inst_id}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The head entry stays in the buffer until its result is taken, so it doubles
  // as the operand register for the whole operation.
  assign {hd_a, hd_b, hd_mode_raw, hd_rd, hd_inst} = fifo_rdata;
  assign hd_mode = mul_mode_e'(hd_mode_raw);
  assign hd_sa   = mode_a_signed(hd_mode);
  assign hd_sb   = mode_b_signed(hd_mode);
  assign hd_zero = (hd_a == '0) || (hd_b == '0);

  // The low half is identical for every signedness, so MUL may reuse any cached product.
  assign cache_hit = cache_vld_q && (cache_a_q == hd_a) && (cache_b_q == hd_b) &&
                     ((hd_mode == MODE_MUL) || ((cache_sa_q == hd_sa) && (cache_sb_q == hd_sb)));

  always_comb begin
    state_d    = state_q;
    start_calc = 1'b0;
    start_fast = 1'b0;
    calc_step  = 1'b0;
    calc_last  = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (hd_zero || cache_hit) begin
            start_fast = 1'b1;
            state_d    = ST_DONE;
          end else begin
            start_calc = 1'b1;
            state_d    = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        calc_step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          calc_last = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (m_mul_res_ready) begin
          fifo_pop = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cache_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush)          cache_vld_q <= 1'b0;
      else if (calc_last) cache_vld_q <= 1'b1;
    end
  end

  // Digit step: LSB digit first; only the top digit carries op_b's sign.
  assign dig      = b_sh_q[K-1:0];
  assign dig_sign = (cnt_q == CNT_LAST) && hd_sb && dig[K-1];
  assign dig_ext  = {{(PW-K){dig_sign}}, dig};
  assign pp       = a_sh_q * dig_ext;
  assign acc_nxt  = acc_q + pp;

  always_ff @(posedge clk) begin
    if (start_calc) begin
      a_sh_q <= {{W{hd_sa & hd_a[W-1]}}, hd_a};
      b_sh_q <= {{(BW-W){hd_sb & hd_b[W-1]}}, hd_b};
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (calc_step) begin
      a_sh_q <= a_sh_q << K;
      b_sh_q <= b_sh_q >> K;
      acc_q  <= acc_nxt;
      cnt_q  <= cnt_q + CNT_W'(1);
    end

    if (start_fast) begin
      res_data_q <= hd_zero ? '0 : sel_half(cache_prod_q, hd_mode);
      res_rd_q   <= hd_rd;
      res_inst_q <= hd_inst;
    end else if (calc_last) begin
      res_data_q <= sel_half(acc_nxt, hd_mode);
      res_rd_q   <= hd_rd;
      res_inst_q <= hd_inst;
    end

    if (calc_last) begin
      cache_prod_q <= acc_nxt;
      cache_a_q    <= hd_a;
      cache_b_q    <= hd_b;
      cache_sa_q   <= hd_sa;
      cache_sb_q   <= hd_sb;
    end
  end

  assign s_mul_req_ready   = !fifo_full;
  assign m_mul_res_valid   = (state_q == ST_DONE);
  assign m_mul_res_data    = res_data_q;
  assign m_mul_res_rd_id   = res_rd_q;
  assign m_mul_res_inst_id = res_inst_q;

endmodule
